// File: rtl/counter_sequencer.sv
// Sequencer for an external 8-bit counter: clear, run to a programmable terminal count,
// one-shot or periodic, with pause, abort and a stall watchdog.
module counter_sequencer #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] DEFAULT_LIMIT = 8'hFF,
  parameter int unsigned      TIMEOUT       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             T,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       wrap_cnt
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] cnt_prev;
  logic [WdW-1:0]   wd_cnt;
  logic             periodic;
  logic             terminal;
  logic             stalled;
  logic             wd_trip;

  assign T        = (state == StRun) && !pause && (cnt_in < limit);
  assign cnt_clr  = (state == StClear);
  assign busy     = (state == StClear) || (state == StRun);
  assign terminal = (state == StRun) && (cnt_in >= limit);
  assign stalled  = T && (cnt_in == cnt_prev);
  // Trips on the TIMEOUT-th consecutive stalled cycle, counting the current one.
  assign wd_trip  = stalled && (wd_cnt == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      limit    <= DEFAULT_LIMIT;
      cnt_prev <= '0;
      wd_cnt   <= '0;
      periodic <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      cnt_prev <= cnt_in;
      done     <= 1'b0;
      wd_cnt   <= (stalled && !wd_trip && !stop) ? wd_cnt + 1'b1 : '0;
      unique case (state)
        StIdle: begin
          if (cfg_we) limit <= cfg_limit;
          if (start) begin
            state    <= StClear;
            periodic <= mode;
            wrap_cnt <= '0;
            err      <= 1'b0;
          end
        end
        StClear: state <= stop ? StIdle : StRun;
        StRun: begin
          if (stop) begin
            state <= StIdle;
          end else if (wd_trip) begin
            state <= StIdle;
            err   <= 1'b1;
          end else if (terminal) begin
            done <= 1'b1;
            if (periodic) begin
              state <= StClear;
              if (wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'd1;
            end else begin
              state <= StDone;
            end
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: an external counter model, a per-cycle behavioural reference,
// directed scenarios with hand-computed timing, then randomized traffic.
module tb_counter_sequencer;
  localparam int TO = 16;
  localparam int P_IDLE = 0, P_CLR = 1, P_RUN = 2, P_DONE = 3;

  logic       clk = 1'b0, reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, mode = 1'b0, cfg_we = 1'b0;
  logic [7:0] cfg_limit = 8'd0;
  logic [7:0] cnt_in;
  logic       T, cnt_clr, busy, done, err;
  logic [7:0] wrap_cnt;

  logic [7:0] cnt = 8'd0, ld_val = 8'd0;
  logic       ld = 1'b0, frz = 1'b0;

  int total = 0, bad = 0, cyc = 0;
  int done_cnt = 0, t_cnt = 0, clr_cnt = 0, pt_cnt = 0;
  int done_q[$];

  assign cnt_in = cnt;
  always #5 clk = ~clk;

  counter_sequencer #(
    .WIDTH(8),
    .DEFAULT_LIMIT(8'hFF),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .mode(mode),
    .cfg_we(cfg_we), .cfg_limit(cfg_limit), .cnt_in(cnt_in), .T(T), .cnt_clr(cnt_clr),
    .busy(busy), .done(done), .err(err), .wrap_cnt(wrap_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Counter being sequenced; ld/frz let the bench force or freeze its value.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) cnt <= ld_val;
    else if (!frz) begin
      if (cnt_clr) cnt <= 8'd0;
      else if (T) cnt <= cnt + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        done_q.push_back(cyc);
      end
      if (T) t_cnt++;
      if (cnt_clr) clr_cnt++;
      if (T && pause) pt_cnt++;
    end
  end

  // Reference model: phase plus run bookkeeping, advanced once per cycle from the rules.
  int         ph = P_IDLE, m_run = 0;
  logic [7:0] m_lim = 8'hFF, m_wrap = 8'd0, m_prev = 8'd0;
  logic       m_per = 1'b0, m_err = 1'b0, m_done = 1'b0, e_t = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      ph = P_IDLE; m_lim = 8'hFF; m_wrap = 8'd0; m_err = 1'b0; m_done = 1'b0;
      m_run = 0; m_per = 1'b0; m_prev = cnt_in;
      chk("rst_T", T, 0); chk("rst_clr", cnt_clr, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_wrap", wrap_cnt, 0);
    end else begin
      e_t = (ph == P_RUN) && !pause && (cnt_in < m_lim);
      chk("T", T, e_t);
      chk("cnt_clr", cnt_clr, ph == P_CLR);
      chk("busy", busy, (ph == P_CLR) || (ph == P_RUN));
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("wrap_cnt", wrap_cnt, m_wrap);
      m_run  = (e_t && cnt_in == m_prev) ? m_run + 1 : 0;
      m_done = 1'b0;
      case (ph)
        P_IDLE: begin
          if (cfg_we) m_lim = cfg_limit;
          if (start) begin ph = P_CLR; m_per = mode; m_wrap = 8'd0; m_err = 1'b0; end
        end
        P_CLR: ph = stop ? P_IDLE : P_RUN;
        P_RUN: begin
          if (stop) ph = P_IDLE;
          else if (m_run >= TO) begin m_err = 1'b1; ph = P_IDLE; end
          else if (cnt_in >= m_lim) begin
            m_done = 1'b1;
            if (m_per) begin
              ph = P_CLR;
              if (m_wrap < 8'd255) m_wrap = m_wrap + 8'd1;
            end else ph = P_DONE;
          end
        end
        default: ph = P_IDLE;
      endcase
      m_prev = cnt_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_stats();
    done_cnt = 0; t_cnt = 0; clr_cnt = 0; pt_cnt = 0;
    done_q.delete();
  endtask

  task automatic cfg(input logic [7:0] l);
    cfg_we = 1'b1; cfg_limit = l;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic launch(input logic m, output int s);
    mode = m; start = 1'b1; s = cyc;
    tick();
    start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && done_cnt == 0; i++) tick();
  endtask

  function automatic int done_at(input int i);
    if (done_q.size() > i) return done_q[i];
    return -1000;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s, pn;
    ticks(3);
    reset = 1'b0;
    tick();
    chk("reset_busy", busy, 0); chk("reset_T", T, 0); chk("reset_wrap", wrap_cnt, 0);

    // One-shot, limit 3
    cfg(8'd3); clear_stats(); launch(1'b0, s); wait_done(30); ticks(3);
    chk("os_done_delay", done_at(0) - s, 6);
    chk("os_t_cycles", t_cnt, 3); chk("os_clr_pulses", clr_cnt, 1);
    chk("os_done_pulses", done_cnt, 1); chk("os_busy_after", busy, 0);

    // Periodic, limit 3, then stop
    clear_stats(); launch(1'b1, s);
    for (int i = 0; i < 60 && done_cnt < 4; i++) tick();
    chk("per_wrap4", wrap_cnt, 4);
    stop = 1'b1; tick(); stop = 1'b0; ticks(10);
    chk("per_first_done", done_at(0) - s, 6);
    for (int i = 1; i < 4; i++) chk("per_interval", done_at(i) - done_at(i - 1), 5);
    chk("per_stop_no_done", done_cnt, 4); chk("per_stop_wrap", wrap_cnt, 4);
    chk("per_stop_busy", busy, 0);

    // Pause for 3 cycles at count 2, limit 5
    cfg(8'd5); clear_stats(); launch(1'b0, s); pn = 0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) begin
      pause = busy && !cnt_clr && cnt_in == 8'd2 && pn < 3;
      if (pause) pn++;
      tick();
    end
    pause = 1'b0; ticks(2);
    chk("pause_done_delay", done_at(0) - s, 11);
    chk("pause_t_cycles", t_cnt, 5); chk("pause_t_while_paused", pt_cnt, 0);

    // Stall watchdog with the counter frozen at 1
    ld_val = 8'd1; ld = 1'b1; tick(); ld = 1'b0; frz = 1'b1;
    clear_stats(); launch(1'b0, s);
    for (int i = 0; i < 60 && !err; i++) tick();
    chk("wd_err_delay", cyc - s, 18);
    ticks(3);
    chk("wd_err_sticky", err, 1); chk("wd_busy", busy, 0); chk("wd_no_done", done_cnt, 0);
    frz = 1'b0; launch(1'b0, s);
    chk("wd_err_cleared", err, 0);
    stop = 1'b1; tick(); stop = 1'b0; ticks(2);

    // Limit 0 loaded together with start
    cfg_we = 1'b1; cfg_limit = 8'd0; clear_stats(); launch(1'b0, s);
    wait_done(20); ticks(2);
    chk("lim0_done_delay", done_at(0) - s, 3); chk("lim0_t_never", t_cnt, 0);

    // cfg_we and start during RUN are ignored
    cfg(8'd3); clear_stats(); launch(1'b0, s); tick();
    cfg_we = 1'b1; cfg_limit = 8'd10; start = 1'b1; tick(); cfg_we = 1'b0; start = 1'b0;
    wait_done(30); ticks(4);
    chk("ign_done_delay", done_at(0) - s, 6); chk("ign_clr_pulses", clr_cnt, 1);
    chk("ign_done_pulses", done_cnt, 1);

    // stop in the terminal-detect cycle
    clear_stats(); launch(1'b0, s);
    for (int i = 0; i < 20 && !(busy && !cnt_clr && cnt_in == 8'd3); i++) tick();
    stop = 1'b1; tick(); stop = 1'b0; ticks(4);
    chk("stop_term_no_done", done_cnt, 0); chk("stop_term_busy", busy, 0);

    // Asynchronous reset mid-run; limit returns to 255
    cfg(8'd1); clear_stats(); launch(1'b1, s); ticks(8);
    #1 reset = 1'b1;
    #1;
    chk("async_T", T, 0); chk("async_clr", cnt_clr, 0); chk("async_busy", busy, 0);
    chk("async_done", done, 0); chk("async_err", err, 0); chk("async_wrap", wrap_cnt, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
    clear_stats(); launch(1'b0, s); wait_done(300); ticks(2);
    chk("full_done_delay", done_at(0) - s, 258); chk("full_t_cycles", t_cnt, 255);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 6) == 0;
      stop      = ($urandom % 50) == 0;
      pause     = ($urandom % 16) == 0;
      mode      = 1'($urandom);
      cfg_we    = ($urandom % 8) == 0;
      cfg_limit = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom % 10);
      if (($urandom % 40) == 0) frz = ~frz;
      tick();
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; cfg_we = 1'b0; frz = 1'b0;
    ticks(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
